// File: rtl/packer_rr_arbiter_pkg.sv
// packer_pkg: shared sizing constants and FSM state type for the packer arbiter.
package packer_pkg;
    localparam int N_REQ   = 4;
    localparam int DATA_W  = 8;
    localparam int BEATS   = 4;
    localparam int LANE_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PHASE_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    typedef enum logic {IDLE, BURST} state_t;
endpackage

// File: rtl/packer_rr_arbiter_picker.sv
// rr_priority_picker: combinational round-robin search from a start pointer, wrapping modulo N_REQ.
module rr_priority_picker #(
    parameter int N_REQ  = 4,
    parameter int LANE_W = 2
) (
    input  logic [N_REQ-1:0]  req,
    input  logic [LANE_W-1:0] start,
    output logic              found,
    output logic [LANE_W-1:0] index
);
    always_comb begin
        int j;
        logic [LANE_W-1:0] idx;
        found = 1'b0;
        index = '0;
        j = 0;
        idx = '0;
        // Walk offsets from farthest to nearest so the closest hit is the last one written.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(start) + k;
            if (j >= N_REQ) j -= N_REQ;
            idx = LANE_W'(j);
            if (req[idx]) begin
                found = 1'b1;
                index = idx;
            end
        end
    end
endmodule

// File: rtl/packer_rr_arbiter.sv
// packer_rr_arbiter: round-robin grant of one requester per word slot onto the shared byte packer bus.
module packer_rr_arbiter
    import packer_pkg::state_t, packer_pkg::IDLE, packer_pkg::BURST;
#(
    parameter int N_REQ  = packer_pkg::N_REQ,
    parameter int DATA_W = packer_pkg::DATA_W,
    parameter int BEATS  = packer_pkg::BEATS,
    localparam int LANE_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int PHASE_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                      clk_4f,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]         bus_data,
    output logic                      bus_valid,
    output logic [LANE_W-1:0]         bus_lane,
    output logic                      bus_first,
    output logic                      bus_last,
    output logic [PHASE_W-1:0]        phase,
    output logic                      err_abort
);
    state_t            state;
    logic [LANE_W-1:0] grant, last_grant, start, winner;
    logic              found, last_beat, accept, drop;
    logic [DATA_W-1:0] lane_byte [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign lane_byte[i] = req_data[i*DATA_W +: DATA_W];
    end

    assign last_beat = phase == PHASE_W'(BEATS - 1);
    assign start     = (last_grant == LANE_W'(N_REQ - 1)) ? '0 : last_grant + 1'b1;
    assign accept    = state == BURST && req_valid[grant] && req_ready[grant];
    assign drop      = state == BURST && !req_valid[grant];

    rr_priority_picker #(.N_REQ(N_REQ), .LANE_W(LANE_W)) u_pick (
        .req   (req_valid),
        .start (start),
        .found (found),
        .index (winner)
    );

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= LANE_W'(N_REQ - 1);
            phase      <= '0;
            req_ready  <= '0;
            bus_data   <= '0;
            bus_valid  <= 1'b0;
            bus_lane   <= '0;
            bus_first  <= 1'b0;
            bus_last   <= 1'b0;
            err_abort  <= 1'b0;
        end else begin
            phase     <= last_beat ? '0 : phase + 1'b1;
            err_abort <= drop;
            bus_valid <= accept;
            bus_data  <= accept ? lane_byte[grant] : '0;
            bus_lane  <= accept ? grant : '0;
            bus_first <= accept && phase == '0;
            bus_last  <= accept && last_beat;
            // Slot boundary: arbitrate even if the current owner just aborted.
            if (last_beat) begin
                state     <= found ? BURST : IDLE;
                req_ready <= found ? (N_REQ'(1) << winner) : '0;
                if (found) begin
                    grant      <= winner;
                    last_grant <= winner;
                end
            end else if (drop) begin
                state     <= IDLE;
                req_ready <= '0;
            end
        end
    end
endmodule

// File: tb/tb_packer_rr_arbiter.sv
// tb_packer_rr_arbiter: directed scenarios and random traffic checked against a slot-level reference model.
module tb_packer_rr_arbiter;
    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;
    localparam int BEATS  = 4;

    logic        clk_4f = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [7:0]  bus_data;
    logic        bus_valid;
    logic [1:0]  bus_lane;
    logic        bus_first, bus_last;
    logic [1:0]  phase;
    logic        err_abort;

    packer_rr_arbiter dut (
        .clk_4f(clk_4f), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .bus_data(bus_data), .bus_valid(bus_valid), .bus_lane(bus_lane),
        .bus_first(bus_first), .bus_last(bus_last), .phase(phase), .err_abort(err_abort)
    );

    always #5 clk_4f = ~clk_4f;

    int n_tests = 0;
    int n_fail = 0;

    // Reference model: tracks which lane owns the current slot (or none) and the rotating pointer.
    int         m_phase = 0, owner = -1, last = N_REQ - 1;
    logic [3:0] e_ready = '0;
    logic [7:0] e_data = '0;
    logic [1:0] e_lane = '0, e_phase = '0;
    logic       e_valid = 1'b0, e_first = 1'b0, e_last = 1'b0, e_abort = 1'b0;

    logic [19:0] dut_o, exp_o;
    assign dut_o = {req_ready, bus_data, bus_valid, bus_lane, bus_first, bus_last, phase, err_abort};
    assign exp_o = {e_ready, e_data, e_valid, e_lane, e_first, e_last, e_phase, e_abort};

    task automatic model_update();
        int p, w;
        logic acc, drp;
        if (reset) begin
            m_phase = 0; owner = -1; last = N_REQ - 1;
            e_ready = '0; e_data = '0; e_valid = 0; e_lane = '0;
            e_first = 0; e_last = 0; e_abort = 0; e_phase = '0;
            return;
        end
        p = m_phase;
        acc = (owner >= 0) && req_valid[owner];
        drp = (owner >= 0) && !req_valid[owner];
        e_abort = drp;
        e_valid = acc;
        e_data = '0;
        e_lane = '0;
        if (acc) begin
            e_data = req_data[owner*DATA_W +: DATA_W];
            e_lane = owner[1:0];
        end
        e_first = acc && p == 0;
        e_last = acc && p == BEATS - 1;
        if (p == BEATS - 1) begin
            w = -1;
            for (int k = 1; k <= N_REQ; k++)
                if (w < 0 && req_valid[(last + k) % N_REQ]) w = (last + k) % N_REQ;
            owner = w;
            if (w >= 0) last = w;
        end else if (drp) owner = -1;
        e_ready = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
        m_phase = (p + 1) % BEATS;
        e_phase = m_phase[1:0];
    endtask

    task automatic tick();
        @(posedge clk_4f);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_tests++;
        if (dut_o !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h want 00000", dut_o);
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if (phase !== 2'd1 || req_ready !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_release phase=%0d ready=%b want phase=1 ready=0000", phase, req_ready);
        end
    endtask

    task automatic test_single_lane();
        int bad = 0, beats = 0;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            req_valid = 4'b0100;
            req_data = $urandom;
            req_data[23:16] = 8'h11 * (c % 4 + 1);
            tick();
            n_tests++;
            if (dut_o !== exp_o) begin
                n_fail++;
                $display("FAIL single_lane c=%0d got %h want %h", c, dut_o, exp_o);
            end
            if (bus_valid) begin
                beats++;
                if (bus_lane !== 2'd2 || bus_data !== 8'(8'h11 * ((int'(phase) + 3) % 4 + 1)) ||
                    bus_first !== (bus_data == 8'h11) || bus_last !== (bus_data == 8'h44)) bad++;
            end
        end
        n_tests++;
        if (bad != 0 || beats != 20) begin
            n_fail++;
            $display("FAIL single_lane_beats bad=%0d beats=%0d want bad=0 beats=20", bad, beats);
        end
    endtask

    task automatic test_all_lanes();
        int order[$];
        do_reset();
        for (int c = 0; c < 24; c++) begin
            req_valid = 4'b1111;
            req_data = $urandom;
            tick();
            n_tests++;
            if (dut_o !== exp_o) begin
                n_fail++;
                $display("FAIL all_lanes c=%0d got %h want %h", c, dut_o, exp_o);
            end
            if (bus_first) order.push_back(int'(bus_lane));
        end
        n_tests++;
        if (order.size() != 5 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3 || order[4] != 0) begin
            n_fail++;
            $display("FAIL all_lanes_order got %p want 0 1 2 3 0", order);
        end
    endtask

    task automatic test_pair();
        int order[$];
        do_reset();
        for (int c = 0; c < 16; c++) begin
            req_valid = (c < 4) ? 4'b0010 : 4'b1010;
            req_data = $urandom;
            tick();
            n_tests++;
            if (dut_o !== exp_o) begin
                n_fail++;
                $display("FAIL pair c=%0d got %h want %h", c, dut_o, exp_o);
            end
            if (bus_first) order.push_back(int'(bus_lane));
        end
        n_tests++;
        if (order.size() != 3 || order[0] != 1 || order[1] != 3 || order[2] != 1) begin
            n_fail++;
            $display("FAIL pair_order got %p want 1 3 1", order);
        end
    endtask

    task automatic test_abort();
        int aborts = 0, next_lane = -1;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            req_valid = {2'b00, c >= 4, c != 6};
            req_data = $urandom;
            tick();
            n_tests++;
            if (dut_o !== exp_o) begin
                n_fail++;
                $display("FAIL abort c=%0d got %h want %h", c, dut_o, exp_o);
            end
            aborts += int'(err_abort);
            if ((c == 6 || c == 7) && (bus_valid !== 1'b0 || req_ready !== 4'b0 && c == 6)) begin
                n_fail++;
                $display("FAIL abort_quiet c=%0d valid=%b ready=%b want valid=0", c, bus_valid, req_ready);
            end
            if (c == 6 || c == 7) n_tests++;
            if (c >= 7 && bus_first && next_lane < 0) next_lane = int'(bus_lane);
        end
        n_tests++;
        if (aborts != 1 || next_lane != 1) begin
            n_fail++;
            $display("FAIL abort_summary pulses=%0d next=%0d want pulses=1 next=1", aborts, next_lane);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            req_valid = 4'b0001;
            req_data = $urandom;
            tick();
        end
        reset = 1'b1;
        tick();
        n_tests++;
        if (dut_o !== 20'h0 || dut_o !== exp_o) begin
            n_fail++;
            $display("FAIL reset_mid got %h want 00000", dut_o);
        end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_tests++;
            if (req_ready !== ((c == 3) ? 4'b0001 : 4'b0000) || err_abort !== 1'b0 || dut_o !== exp_o) begin
                n_fail++;
                $display("FAIL reset_mid_regrant c=%0d ready=%b abort=%b got %h want %h", c, req_ready, err_abort, dut_o, exp_o);
            end
        end
    endtask

    task automatic test_late_raise();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            req_valid = (c >= 5) ? 4'b1000 : 4'b0000;
            req_data = $urandom;
            tick();
            if (c >= 5) begin
                n_tests++;
                if (req_ready !== ((c == 7) ? 4'b1000 : 4'b0000)) begin
                    n_fail++;
                    $display("FAIL late_raise c=%0d ready=%b want %b", c, req_ready, (c == 7) ? 4'b1000 : 4'b0000);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(99) == 0);
            for (int l = 0; l < N_REQ; l++) req_valid[l] = ($urandom_range(7) != 0) && ($urandom_range(3) != l);
            req_data = $urandom;
            tick();
            n_tests++;
            if (dut_o !== exp_o) begin
                n_fail++;
                $display("FAIL random c=%0d got %h want %h", c, dut_o, exp_o);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_all_lanes();
        test_pair();
        test_abort();
        test_reset_mid();
        test_late_raise();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
